// File: rtl/decode_branch_unit_if.sv
// Fetch-side and consumer-side handshake bundle for decode_branch_unit.
// master = fetch/consumer side, slave = decoder.
interface decode_branch_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              wZa, wCa, wNa;
  logic              wZb, wCb, wNb;
  logic              out_valid;
  logic              out_ready;
  logic              rBranch_taken;
  logic              rJumpTaken;
  logic [ADDR_W-1:0] rBranch_dir;
  logic [DATA_W-1:0] rC;
  logic              rMux_a_sel;
  logic              rMux_b_sel;
  logic              rIllegal;

  modport master (
    output in_valid, in_instr, in_pc, wZa, wCa, wNa, wZb, wCb, wNb, out_ready,
    input  in_ready, out_valid, rBranch_taken, rJumpTaken, rBranch_dir, rC,
           rMux_a_sel, rMux_b_sel, rIllegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wZa, wCa, wNa, wZb, wCb, wNb, out_ready,
    output in_ready, out_valid, rBranch_taken, rJumpTaken, rBranch_dir, rC,
           rMux_a_sel, rMux_b_sel, rIllegal
  );
endinterface

// File: rtl/decode_branch_unit.sv
// Pipelined decoder / branch resolver for the A/B accumulator core: one-cycle
// registered output, flag-hazard interlock for branches and branch-shadow squash.
module decode_branch_unit #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int BR_OFF_W = 7,
  parameter bit REL_BR   = 1'b0,
  parameter int FLAG_LAT = 2,
  parameter int SHADOW   = 1
) (
  input logic Clock,
  input logic Reset,
  decode_branch_unit_if.slave bus
);
  localparam int FC_W = (FLAG_LAT > 0) ? $clog2(FLAG_LAT + 1) : 1;

  typedef struct packed {
    logic              branchTaken;
    logic              jumpTaken;
    logic [ADDR_W-1:0] branchDir;
    logic [DATA_W-1:0] c;
    logic              muxA;
    logic              muxB;
    logic              illegal;
  } dec_t;

  dec_t                   dec, decQ;
  logic                   outValidQ;
  logic [1:0][FC_W-1:0]   flagCnt;
  logic [1:0]             shadowCnt;
  logic [5:0]             op;
  logic                   wrFlags, flagVal, hazard, squash, accept, redirect;
  logic [ADDR_W-1:0]      offZ, offS, relTarget;

  assign op        = bus.in_instr[15:10];
  assign offZ      = ADDR_W'(bus.in_instr[BR_OFF_W-1:0]);
  assign offS      = ADDR_W'($signed(bus.in_instr[BR_OFF_W-1:0]));
  assign relTarget = bus.in_pc + ADDR_W'(1) + offS;

  always_comb begin
    dec     = '0;
    wrFlags = 1'b0;
    flagVal = 1'b0;
    case (op[5:4])
      2'b00: wrFlags = (op[2:0] != 3'b001);
      2'b01: begin
        if (op[2:0] inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101}) begin
          dec.c    = bus.in_instr[DATA_W-1:0];
          dec.muxA = ~op[3];
          dec.muxB = op[3];
          wrFlags  = 1'b1;
        end else dec.illegal = 1'b1;
      end
      2'b10: begin
        case (op[2:1])
          2'b00:   flagVal = op[3] ? bus.wZb : bus.wZa;
          2'b01:   flagVal = op[3] ? bus.wCb : bus.wCa;
          2'b10:   flagVal = op[3] ? bus.wNb : bus.wNa;
          default: dec.illegal = 1'b1;
        endcase
        if (!dec.illegal && (flagVal == op[0])) begin
          dec.branchTaken = 1'b1;
          dec.branchDir   = REL_BR ? relTarget : offZ;
        end
      end
      default: begin
        if (op == 6'b110000) begin
          dec.jumpTaken = 1'b1;
          dec.branchDir = bus.in_instr[ADDR_W-1:0];
        end else dec.illegal = 1'b1;
      end
    endcase
  end

  // Squashed instructions never execute, so they cannot be held by the flag interlock.
  assign squash       = (shadowCnt != 2'd0);
  assign hazard       = (op[5:4] == 2'b10) && (flagCnt[op[3]] != '0) && !squash;
  assign bus.in_ready = (~outValidQ | bus.out_ready) & ~hazard;
  assign accept       = bus.in_valid & bus.in_ready;
  assign redirect     = dec.branchTaken | dec.jumpTaken;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      decQ      <= '0;
      outValidQ <= 1'b0;
      flagCnt   <= '0;
      shadowCnt <= '0;
    end else begin
      if (accept && !squash) begin
        decQ      <= dec;
        outValidQ <= 1'b1;
      end else if (bus.out_ready) begin
        decQ      <= '0;
        outValidQ <= 1'b0;
      end

      for (int x = 0; x < 2; x++) begin
        if (accept && !squash && wrFlags && (op[3] == x[0]))
          flagCnt[x] <= FC_W'(FLAG_LAT);
        else if (flagCnt[x] != '0)
          flagCnt[x] <= flagCnt[x] - FC_W'(1);
      end

      if (accept && squash)
        shadowCnt <= shadowCnt - 2'd1;
      else if (accept && redirect)
        shadowCnt <= 2'(SHADOW);
    end
  end

  assign bus.out_valid     = outValidQ;
  assign bus.rBranch_taken = decQ.branchTaken;
  assign bus.rJumpTaken    = decQ.jumpTaken;
  assign bus.rBranch_dir   = decQ.branchDir;
  assign bus.rC            = decQ.c;
  assign bus.rMux_a_sel    = decQ.muxA;
  assign bus.rMux_b_sel    = decQ.muxB;
  assign bus.rIllegal      = decQ.illegal;
endmodule

// File: tb/tb_decode_branch_unit.sv
// Directed bench for decode_branch_unit: a vector table plus hand-written
// sequences for reset, interlock, shadow, PC-relative wrap and back-pressure.
module tb_decode_branch_unit;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  decode_branch_unit_if #(.DATA_W(8), .ADDR_W(10)) b1 ();
  decode_branch_unit_if #(.DATA_W(8), .ADDR_W(10)) b2 ();

  decode_branch_unit #(.DATA_W(8), .ADDR_W(10), .BR_OFF_W(7), .REL_BR(1'b0),
                       .FLAG_LAT(2), .SHADOW(1))
    dutAbs (.Clock(Clock), .Reset(Reset), .bus(b1));
  decode_branch_unit #(.DATA_W(8), .ADDR_W(10), .BR_OFF_W(7), .REL_BR(1'b1),
                       .FLAG_LAT(2), .SHADOW(1))
    dutRel (.Clock(Clock), .Reset(Reset), .bus(b2));

  // {valid, taken, jump, illegal, muxA, muxB, dir[9:0], c[7:0]}
  logic [23:0] o1, o2;
  assign o1 = {b1.out_valid, b1.rBranch_taken, b1.rJumpTaken, b1.rIllegal,
               b1.rMux_a_sel, b1.rMux_b_sel, b1.rBranch_dir, b1.rC};
  assign o2 = {b2.out_valid, b2.rBranch_taken, b2.rJumpTaken, b2.rIllegal,
               b2.rMux_a_sel, b2.rMux_b_sel, b2.rBranch_dir, b2.rC};

  int nChk  = 0;
  int nPass = 0;

  function automatic logic [23:0] ex(input bit v, bt, jt, il, sa, sb,
                                     input logic [9:0] dir, input logic [7:0] c);
    return {v, bt, jt, il, sa, sb, dir, c};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [23:0] act, input logic [23:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  // Present one instruction (flags {Za,Ca,Na,Zb,Cb,Nb}) until accepted; returns stall cycles.
  task automatic send(input bit rel, input logic [15:0] ins, input logic [9:0] pc,
                      input logic [5:0] fl, output int stalls);
    stalls = 0;
    if (rel) begin
      b2.in_valid = 1'b1; b2.in_instr = ins; b2.in_pc = pc;
      {b2.wZa, b2.wCa, b2.wNa, b2.wZb, b2.wCb, b2.wNb} = fl;
    end else begin
      b1.in_valid = 1'b1; b1.in_instr = ins; b1.in_pc = pc;
      {b1.wZa, b1.wCa, b1.wNa, b1.wZb, b1.wCb, b1.wNb} = fl;
    end
    #1;
    while (!(rel ? b2.in_ready : b1.in_ready) && stalls < 20) begin
      @(posedge Clock); #1; stalls++;
    end
    if (stalls >= 20) begin
      nChk++;
      $display("FAIL accept_timeout: instr %h never accepted, limit 20 cycles", ins);
    end
    @(posedge Clock); #1;
    if (rel) b2.in_valid = 1'b0; else b1.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [5:0]  fl;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    b1.in_valid = 0; b1.in_instr = '0; b1.in_pc = '0; b1.out_ready = 1;
    {b1.wZa, b1.wCa, b1.wNa, b1.wZb, b1.wCb, b1.wNb} = '0;
    b2.in_valid = 0; b2.in_instr = '0; b2.in_pc = '0; b2.out_ready = 1;
    {b2.wZa, b2.wCa, b2.wNa, b2.wZb, b2.wCb, b2.wNb} = '0;

    vt[0]  = '{16'h405A, 6'b000000, ex(1,0,0,0,1,0,10'h000,8'h5A)}; // LDC A
    vt[1]  = '{16'h60C3, 6'b000000, ex(1,0,0,0,0,1,10'h000,8'hC3)}; // LDC B
    vt[2]  = '{16'h740F, 6'b000000, ex(1,0,0,0,0,1,10'h000,8'h0F)}; // ORC B
    vt[3]  = '{16'h0800, 6'b000000, ex(1,0,0,0,0,0,10'h000,8'h00)}; // ADD A
    vt[4]  = '{16'h4455, 6'b000000, ex(1,0,0,1,0,0,10'h000,8'h00)}; // imm op 001
    vt[5]  = '{16'h8425, 6'b100000, ex(1,1,0,0,0,0,10'h025,8'h00)}; // Z_A set, taken
    vt[6]  = '{16'h8425, 6'b011111, ex(1,0,0,0,0,0,10'h000,8'h00)}; // Z_A clear
    vt[7]  = '{16'hA813, 6'b111101, ex(1,1,0,0,0,0,10'h013,8'h00)}; // C_B clear, taken
    vt[8]  = '{16'h97FF, 6'b001000, ex(1,1,0,0,0,0,10'h07F,8'h00)}; // N_A set, high bits masked
    vt[9]  = '{16'h9800, 6'b111111, ex(1,0,0,1,0,0,10'h000,8'h00)}; // flag field 11
    vt[10] = '{16'hC3FF, 6'b000000, ex(1,0,1,0,0,0,10'h3FF,8'h00)}; // JMP
    vt[11] = '{16'hC400, 6'b000000, ex(1,0,0,1,0,0,10'h000,8'h00)}; // op 110001
    vt[12] = '{16'hFC00, 6'b000000, ex(1,0,0,1,0,0,10'h000,8'h00)}; // op 111111

    // Reset state
    idle(2);
    chk("reset_outputs", 0, o1, 24'h0);
    chk("reset_in_ready", 0, {23'h0, b1.in_ready}, 24'h1);
    Reset = 1'b1;
    idle(1);

    // Reset asserted while holding a result with flag_cnt[A] loaded
    b1.out_ready = 0;
    send(0, 16'h405A, 10'h0, 6'b0, st);
    chk("hold_before_reset", 0, o1, ex(1,0,0,0,1,0,10'h000,8'h5A));
    Reset = 1'b0;
    #1;
    chk("async_reset_outputs", 0, o1, 24'h0);
    idle(1);
    Reset = 1'b1;
    b1.out_ready = 1;
    send(0, 16'h8425, 10'h0, 6'b100000, st);
    chk("post_reset_stalls", 0, 24'(st), 24'd0);
    chk("post_reset_branch", 0, o1, ex(1,1,0,0,0,0,10'h025,8'h00));
    send(0, 16'h0000, 10'h0, 6'b0, st);
    chk("post_reset_shadow", 0, o1, 24'h0);
    idle(3);

    // Vector table; each taken branch/jump is followed by one squashed filler
    for (int i = 0; i < 13; i++) begin
      send(0, vt[i].ins, 10'h0, vt[i].fl, st);
      chk("vec", i, o1, vt[i].exp);
      if (vt[i].exp[22] || vt[i].exp[21]) begin
        send(0, 16'h0000, 10'h0, 6'b0, st);
        chk("vec_shadow", i, o1, 24'h0);
      end
      idle(3);
      chk("vec_drain", i, o1, 24'h0);
    end

    // Flag interlock: ADD A then branch on Z_A back-to-back
    send(0, 16'h0800, 10'h0, 6'b0, st);
    send(0, 16'h8425, 10'h0, 6'b100000, st);
    chk("interlock_stalls", 0, 24'(st), 24'd2);
    chk("interlock_branch", 0, o1, ex(1,1,0,0,0,0,10'h025,8'h00));
    send(0, 16'h0000, 10'h0, 6'b0, st);
    idle(3);

    // JMP shadow: LDCB squashed, LDCA emitted
    send(0, 16'hC3FF, 10'h0, 6'b0, st);
    chk("jmp", 0, o1, ex(1,0,1,0,0,0,10'h3FF,8'h00));
    send(0, 16'h6011, 10'h0, 6'b0, st);
    chk("jmp_squash", 0, o1, 24'h0);
    send(0, 16'h4022, 10'h0, 6'b0, st);
    chk("jmp_after", 0, o1, ex(1,0,0,0,1,0,10'h000,8'h22));
    idle(3);

    // PC-relative branches, including address wrap
    send(1, 16'hA87F, 10'h3FE, 6'b000000, st);
    chk("rel_minus1", 0, o2, ex(1,1,0,0,0,0,10'h3FE,8'h00));
    send(1, 16'h0000, 10'h0, 6'b0, st);
    chk("rel_shadow", 0, o2, 24'h0);
    send(1, 16'hA801, 10'h3FE, 6'b000000, st);
    chk("rel_wrap", 0, o2, ex(1,1,0,0,0,0,10'h000,8'h00));
    send(1, 16'h0000, 10'h0, 6'b0, st);
    send(1, 16'hA805, 10'h100, 6'b000010, st);
    chk("rel_not_taken", 0, o2, ex(1,0,0,0,0,0,10'h000,8'h00));
    idle(3);

    // Back-pressure: result held for 3 cycles, then an illegal opcode
    send(0, 16'h6011, 10'h0, 6'b0, st);
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_instr = 16'hFC00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_hold", k, o1, ex(1,0,0,0,0,1,10'h000,8'h11));
      chk("stall_ready", k, {23'h0, b1.in_ready}, 24'h0);
      @(posedge Clock); #1;
    end
    b1.out_ready = 1;
    @(posedge Clock); #1;
    b1.in_valid = 0;
    chk("illegal_after_stall", 0, o1, ex(1,0,0,1,0,0,10'h000,8'h00));
    idle(1);
    chk("final_drain", 0, o1, 24'h0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
